// File: rtl/vector_pkg.sv
// vector_pkg: coordinate type and scan FSM states shared by the scan generator.
package vector_pkg;
    localparam int FP_W = 32;
    typedef logic [FP_W-1:0] fp;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} scan_state_t;
endpackage

// File: rtl/pixel_scan_gen_credit.sv
// credit_counter: tracks accepted-but-unretired coordinates and flags retires with nothing outstanding.
module credit_counter #(
    parameter int MAX_INFLIGHT = 16,
    parameter int CNT_W = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic             out_stream_aclk,
    input  logic             periph_resetn,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             has_credit,
    output logic             underflow
);
    logic dec_ok;
    assign dec_ok = dec && count != '0;
    assign has_credit = count < CNT_W'(MAX_INFLIGHT);
    // inc is only ever raised while has_credit, so count cannot pass MAX_INFLIGHT
    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            count     <= '0;
            underflow <= 1'b0;
        end else begin
            count     <= count + CNT_W'(inc) - CNT_W'(dec_ok);
            underflow <= underflow | (dec & ~|count);
        end
    end
endmodule

// File: rtl/pixel_scan_gen.sv
// pixel_scan_gen: raster scan of fixed-point (x, y) coordinates with valid/ready
// handshake and an in-flight credit limit toward the ray-march pipeline.
module pixel_scan_gen
    import vector_pkg::*;
#(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int COORD_W      = FP_W,
    parameter int MAX_INFLIGHT = 16,
    parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic               out_stream_aclk,
    input  logic               periph_resetn,
    input  logic               cfg_start,
    input  logic               cfg_continuous,
    input  logic [COORD_W-1:0] cfg_x0,
    input  logic [COORD_W-1:0] cfg_y0,
    input  logic [COORD_W-1:0] cfg_step,
    output logic [COORD_W-1:0] coord_x,
    output logic [COORD_W-1:0] coord_y,
    output logic               coord_sof,
    output logic               coord_eol,
    output logic               coord_valid,
    input  logic               coord_ready,
    input  logic               retire,
    output logic               busy,
    output logic               frame_done,
    output logic [CNT_W-1:0]   inflight,
    output logic               err_underflow
);
    localparam int CW = H_RES > 1 ? $clog2(H_RES) : 1;
    localparam int RW = V_RES > 1 ? $clog2(V_RES) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(H_RES - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(V_RES - 1);

    scan_state_t        state;
    logic [CW-1:0]      col;
    logic [RW-1:0]      row;
    logic [COORD_W-1:0] x0_s, step_s;
    logic               has_credit, accept, relaunch;

    assign coord_valid = state == RUN && has_credit;
    assign accept      = coord_valid && coord_ready;
    assign coord_sof   = coord_valid && col == '0 && row == '0;
    assign coord_eol   = coord_valid && col == COL_LAST;
    assign busy        = state != IDLE;
    assign relaunch    = (state == IDLE && (cfg_start || cfg_continuous)) ||
                         (state == DRAIN && frame_done && cfg_continuous);

    credit_counter #(.MAX_INFLIGHT(MAX_INFLIGHT), .CNT_W(CNT_W)) u_credit (
        .out_stream_aclk(out_stream_aclk),
        .periph_resetn  (periph_resetn),
        .inc            (accept),
        .dec            (retire),
        .count          (inflight),
        .has_credit     (has_credit),
        .underflow      (err_underflow)
    );

    // frame_done is a one-cycle DRAIN sub-step; the exit decision waits for it
    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            state      <= IDLE;
            col        <= '0;
            row        <= '0;
            coord_x    <= '0;
            coord_y    <= '0;
            x0_s       <= '0;
            step_s     <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= state == DRAIN && !frame_done && inflight == '0;
            if (relaunch) begin
                state   <= RUN;
                col     <= '0;
                row     <= '0;
                coord_x <= cfg_x0;
                coord_y <= cfg_y0;
                x0_s    <= cfg_x0;
                step_s  <= cfg_step;
            end else if (state == DRAIN && frame_done) begin
                state <= IDLE;
            end else if (accept) begin
                if (col != COL_LAST) begin
                    col     <= col + 1'b1;
                    coord_x <= coord_x + step_s;
                end else if (row != ROW_LAST) begin
                    col     <= '0;
                    row     <= row + 1'b1;
                    coord_x <= x0_s;
                    coord_y <= coord_y + step_s;
                end else begin
                    state <= DRAIN;
                end
            end
        end
    end
endmodule

// File: tb/tb_pixel_scan_gen.sv
// tb_pixel_scan_gen: scoreboard bench for a 4x2 raster with a two-deep credit limit.
module tb_pixel_scan_gen;
    localparam logic [31:0] STEP = 32'h0020_0000;
    localparam logic [31:0] X2   = 32'h0100_0000;
    localparam logic [31:0] Y1   = 32'h0000_1000;

    typedef struct packed {
        logic [31:0] x;
        logic [31:0] y;
        logic        sof;
        logic        eol;
    } beat_t;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        cfg_start = 1'b0, cfg_continuous = 1'b0;
    logic [31:0] cfg_x0 = '0, cfg_y0 = '0, cfg_step = '0;
    logic [31:0] coord_x, coord_y;
    logic        coord_sof, coord_eol, coord_valid;
    logic        coord_ready = 1'b0, retire = 1'b0;
    logic        busy, frame_done, err_underflow;
    logic [1:0]  inflight;
    logic        auto_ret = 1'b0, hit = 1'b0;
    beat_t       exp_q[$];
    int          checks = 0, failures = 0;

    pixel_scan_gen #(.H_RES(4), .V_RES(2), .COORD_W(32), .MAX_INFLIGHT(2)) dut (
        .out_stream_aclk(clk),
        .periph_resetn  (rst_n),
        .cfg_start      (cfg_start),
        .cfg_continuous (cfg_continuous),
        .cfg_x0         (cfg_x0),
        .cfg_y0         (cfg_y0),
        .cfg_step       (cfg_step),
        .coord_x        (coord_x),
        .coord_y        (coord_y),
        .coord_sof      (coord_sof),
        .coord_eol      (coord_eol),
        .coord_valid    (coord_valid),
        .coord_ready    (coord_ready),
        .retire         (retire),
        .busy           (busy),
        .frame_done     (frame_done),
        .inflight       (inflight),
        .err_underflow  (err_underflow)
    );

    always #5 clk = ~clk;

    // downstream model: each accepted coordinate retires one cycle later
    initial forever begin
        @(negedge clk);
        hit = rst_n && coord_valid && coord_ready;
        @(posedge clk);
        #1;
        if (auto_ret) retire = hit;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [31:0] x0, input logic [31:0] y0, input logic [31:0] st);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++)
                exp_q.push_back('{x: x0 + 32'(c) * st, y: y0 + 32'(r) * st, sof: r == 0 && c == 0, eol: c == 3});
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({coord_valid, busy, coord_sof, coord_eol, frame_done, err_underflow} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags valid/busy/sof/eol/done/err=%b required 000000",
                     {coord_valid, busy, coord_sof, coord_eol, frame_done, err_underflow});
        end
        checks++;
        if ({coord_x, coord_y, inflight} !== 66'b0) begin
            failures++;
            $display("FAIL reset_values x=%h y=%h inflight=%0d required 0", coord_x, coord_y, inflight);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic;
        int    fd = 0;
        beat_t e;
        cfg_x0 = '0; cfg_y0 = '0; cfg_step = STEP; coord_ready = 1'b1; auto_ret = 1'b1;
        push_frame('0, '0, STEP);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (c == 0) begin
                checks++;
                if ({busy, coord_valid, coord_sof} !== 3'b111) begin
                    failures++;
                    $display("FAIL basic_start busy/valid/sof=%b required 111", {busy, coord_valid, coord_sof});
                end
            end
            if (frame_done) fd++;
            if (coord_valid && coord_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL basic_extra_beat x=%h y=%h required no beat", coord_x, coord_y);
                end else begin
                    e = exp_q.pop_front();
                    if ({coord_x, coord_y, coord_sof, coord_eol} !== e) begin
                        failures++;
                        $display("FAIL basic_beat x=%h y=%h sof=%b eol=%b required x=%h y=%h sof=%b eol=%b",
                                 coord_x, coord_y, coord_sof, coord_eol, e.x, e.y, e.sof, e.eol);
                    end
                end
            end
        end
        checks++;
        if (exp_q.size() != 0 || fd != 1 || busy !== 1'b0 || err_underflow !== 1'b0) begin
            failures++;
            $display("FAIL basic_end left=%0d frame_done=%0d busy=%b err=%b required 0/1/0/0",
                     exp_q.size(), fd, busy, err_underflow);
        end
        exp_q.delete();
        tick();
    endtask

    task automatic test_backpressure;
        beat_t e;
        logic  stalled = 1'b0;
        logic [65:0] held = '0;
        coord_ready = 1'b0; auto_ret = 1'b1;
        push_frame('0, '0, STEP);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (stalled) begin
                checks++;
                if (coord_valid !== 1'b1 || {coord_x, coord_y, coord_sof, coord_eol} !== held) begin
                    failures++;
                    $display("FAIL stall_stable valid=%b x=%h y=%h required valid=1 held=%h",
                             coord_valid, coord_x, coord_y, held);
                end
            end
            stalled = coord_valid && !coord_ready;
            held = {coord_x, coord_y, coord_sof, coord_eol};
            if (coord_valid && coord_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL bp_extra_beat x=%h y=%h required no beat", coord_x, coord_y);
                end else begin
                    e = exp_q.pop_front();
                    if ({coord_x, coord_y, coord_sof, coord_eol} !== e) begin
                        failures++;
                        $display("FAIL bp_beat x=%h y=%h sof=%b eol=%b required x=%h y=%h sof=%b eol=%b",
                                 coord_x, coord_y, coord_sof, coord_eol, e.x, e.y, e.sof, e.eol);
                    end
                end
            end
            if (exp_q.size() == 0 && !busy) break;
            @(posedge clk);
            #1;
            coord_ready = 1'($urandom_range(0, 1));
        end
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_end left=%0d busy=%b required 0/0", exp_q.size(), busy);
        end
        exp_q.delete();
        coord_ready = 1'b1;
        tick();
    endtask

    task automatic test_credit;
        int    n;
        beat_t e;
        auto_ret = 1'b0; retire = 1'b0; coord_ready = 1'b1;
        push_frame('0, '0, STEP);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int phase = 0; phase < 2; phase++) begin
            n = 0;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (coord_valid && coord_ready) begin
                    n++;
                    e = exp_q.pop_front();
                    checks++;
                    if ({coord_x, coord_y, coord_sof, coord_eol} !== e) begin
                        failures++;
                        $display("FAIL credit_beat x=%h y=%h required x=%h y=%h", coord_x, coord_y, e.x, e.y);
                    end
                end
            end
            checks++;
            if (n != 2 - phase || coord_valid !== 1'b0 || inflight !== 2'd2) begin
                failures++;
                $display("FAIL credit_limit phase=%0d accepts=%0d valid=%b inflight=%0d required %0d/0/2",
                         phase, n, coord_valid, inflight, 2 - phase);
            end
            tick();
            retire = 1'b1;
            tick();
            retire = 1'b0;
            if (phase == 1) begin
                coord_ready = 1'b0;
                retire = 1'b1;
                tick();
                retire = 1'b0;
            end
        end
        coord_ready = 1'b1;
        auto_ret = 1'b1;
        for (int c = 0; c < 40 && (exp_q.size() != 0 || busy); c++) begin
            @(negedge clk);
            if (coord_valid && coord_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({coord_x, coord_y, coord_sof, coord_eol} !== e) begin
                    failures++;
                    $display("FAIL credit_rest x=%h y=%h required x=%h y=%h", coord_x, coord_y, e.x, e.y);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0 || err_underflow !== 1'b0) begin
            failures++;
            $display("FAIL credit_end left=%0d busy=%b err=%b required 0/0/0", exp_q.size(), busy, err_underflow);
        end
        exp_q.delete();
        tick();
    endtask

    task automatic test_continuous;
        int    fd = 0;
        logic  want_sof = 1'b0;
        beat_t e;
        cfg_x0 = '0; cfg_y0 = '0; coord_ready = 1'b1; auto_ret = 1'b1;
        push_frame('0, '0, STEP);
        push_frame(X2, '0, STEP);
        cfg_continuous = 1'b1;
        for (int c = 0; c < 80; c++) begin
            @(negedge clk);
            if (want_sof) begin
                checks++;
                if ({coord_valid, coord_sof} !== 2'b11 || coord_x !== X2) begin
                    failures++;
                    $display("FAIL cont_next_sof valid/sof=%b x=%h required 11 x=%h", {coord_valid, coord_sof}, coord_x, X2);
                end
                want_sof = 1'b0;
            end
            if (frame_done) begin
                want_sof = fd == 0;
                fd++;
            end
            if (coord_valid && coord_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({coord_x, coord_y, coord_sof, coord_eol} !== e) begin
                    failures++;
                    $display("FAIL cont_beat x=%h y=%h sof=%b required x=%h y=%h sof=%b",
                             coord_x, coord_y, coord_sof, e.x, e.y, e.sof);
                end
            end
            if (exp_q.size() == 13) cfg_x0 = X2;
            if (exp_q.size() < 8) cfg_continuous = 1'b0;
            if (fd == 2 && !busy) break;
        end
        checks++;
        if (exp_q.size() != 0 || fd != 2 || busy !== 1'b0) begin
            failures++;
            $display("FAIL cont_end left=%0d frame_done=%0d busy=%b required 0/2/0", exp_q.size(), fd, busy);
        end
        exp_q.delete();
        tick();
    endtask

    task automatic test_reset_midframe;
        int    n = 0;
        logic  seen = 1'b0;
        beat_t e;
        cfg_continuous = 1'b0; cfg_x0 = X2; cfg_y0 = Y1; coord_ready = 1'b1; auto_ret = 1'b1;
        push_frame(X2, Y1, STEP);
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        for (int c = 0; c < 20 && n < 5; c++) begin
            @(negedge clk);
            if (coord_valid && coord_ready) begin
                n++;
                e = exp_q.pop_front();
                checks++;
                if ({coord_x, coord_y, coord_sof, coord_eol} !== e) begin
                    failures++;
                    $display("FAIL rst_pre_beat x=%h y=%h required x=%h y=%h", coord_x, coord_y, e.x, e.y);
                end
            end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({coord_valid, busy, coord_sof, coord_eol, frame_done, err_underflow, inflight, coord_x, coord_y} !== 72'b0) begin
            failures++;
            $display("FAIL rst_mid_clear valid=%b busy=%b inflight=%0d x=%h y=%h required all 0",
                     coord_valid, busy, inflight, coord_x, coord_y);
        end
        exp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (coord_valid || busy) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL rst_idle_after valid_or_busy=1 required 0");
        end
        tick();
        rst_n = 1'b0;
        cfg_continuous = 1'b1;
        tick();
        push_frame(X2, Y1, STEP);
        rst_n = 1'b1;
        for (int c = 0; c < 40 && (exp_q.size() != 0 || busy); c++) begin
            @(negedge clk);
            if (coord_valid && coord_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({coord_x, coord_y, coord_sof, coord_eol} !== e) begin
                    failures++;
                    $display("FAIL rst_restart_beat x=%h y=%h sof=%b required x=%h y=%h sof=%b",
                             coord_x, coord_y, coord_sof, e.x, e.y, e.sof);
                end
            end
            if (exp_q.size() < 8) cfg_continuous = 1'b0;
        end
        checks++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rst_restart_end left=%0d busy=%b required 0/0", exp_q.size(), busy);
        end
        exp_q.delete();
        tick();
    endtask

    task automatic test_underflow;
        auto_ret = 1'b0; retire = 1'b0; coord_ready = 1'b0; cfg_continuous = 1'b0;
        cfg_x0 = '0; cfg_y0 = '0;
        retire = 1'b1;
        tick();
        retire = 1'b0;
        @(negedge clk);
        checks++;
        if (err_underflow !== 1'b1 || inflight !== 2'd0) begin
            failures++;
            $display("FAIL underflow_set err=%b inflight=%0d required 1/0", err_underflow, inflight);
        end
        tick();
        tick();
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        coord_ready = 1'b1;
        tick();
        retire = 1'b1;
        tick();
        retire = 1'b0;
        coord_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (inflight !== 2'd1 || coord_x !== 2 * STEP || err_underflow !== 1'b1) begin
            failures++;
            $display("FAIL same_cycle inflight=%0d x=%h err=%b required 1 x=%h err=1",
                     inflight, coord_x, err_underflow, 2 * STEP);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_credit();
        test_continuous();
        test_reset_midframe();
        test_underflow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pixel_scan_gen.md
# pixel_scan_gen

Parametrised screen-coordinate scan generator feeding the ray-march pipeline ahead of the pixel packer. It emits one fixed-point (x, y) pair per accepted beat over a configurable H_RES × V_RES raster, with start-of-frame and end-of-line flags. A valid/ready handshake applies backpressure. An in-flight credit limit keeps outstanding coordinates within the downstream pipeline depth. It supports single-shot and continuous frame modes, replacing the hard-wired 640×480, step-1/8 counter.

## Interface
- H_RES, 640: pixels per line
- V_RES, 480: lines per frame
- COORD_W, 32: coordinate width, two's-complement fixed point (Q8.24 at default)
- MAX_INFLIGHT, 16: maximum accepted-but-unretired coordinates
- CNT_W, $clog2(MAX_INFLIGHT+1): inflight counter width

Ports:
- out_stream_aclk  in  1  sole clock
- periph_resetn  in  1  asynchronous, active-low reset
- cfg_start  in  1  one-cycle pulse, begins a frame from IDLE
- cfg_continuous  in  1  1 = restart automatically after each frame
- cfg_x0, cfg_y0  in  COORD_W  coordinate of pixel (0,0)
- cfg_step  in  COORD_W  per-pixel and per-line increment
- coord_x, coord_y  out  COORD_W  current coordinate
- coord_sof  out  1  high on pixel (0,0)
- coord_eol  out  1  high on column H_RES-1
- coord_valid  out  1  coordinate offered
- coord_ready  in  1  downstream accepts
- retire  in  1  one-cycle pulse per result leaving the downstream pipeline
- busy  out  1  state ≠ IDLE
- frame_done  out  1  one-cycle pulse after the last result retires
- inflight  out  CNT_W  outstanding count
- err_underflow  out  1  sticky; set by retire while inflight = 0

## Operation
- Accept = coord_valid & coord_ready. Retire = retire & (inflight > 0).
- States:
  - IDLE: coord_valid = 0. cfg_start or cfg_continuous → RUN, latching cfg_x0/y0/step into shadow registers, col = row = 0, x = x0, y = y0.
  - RUN: coord_valid = (inflight < MAX_INFLIGHT). On accept:
    - col < H_RES-1: col++, x += step.
    - col = H_RES-1 and row < V_RES-1: col = 0, x = x0, row++, y += step.
    - col = H_RES-1 and row = V_RES-1 (last pixel): → DRAIN.
  - DRAIN: coord_valid = 0. When inflight = 0: pulse frame_done. Then → RUN with fresh config latch if cfg_continuous, else → IDLE.
- Config changes during a frame have no effect until the next latch.
- inflight: +1 on accept, −1 on retire, unchanged when both occur in one cycle. Never exceeds MAX_INFLIGHT; never wraps below 0.
- Coordinate arithmetic is modulo 2^COORD_W and silently wraps.
- coord_sof = (col = 0 & row = 0). coord_eol = (col = H_RES-1). Both are valid only with coord_valid.
- While coord_valid & !coord_ready, coord_x/y/sof/eol stay stable, and coord_valid does not drop unless a credit limit is reached before acceptance. A credit limit cannot occur at that point, because inflight only decreases while waiting.

## Timing
- Reset values: state IDLE; col/row/inflight 0; coord_x/y 0; coord_valid, coord_sof, coord_eol, busy, frame_done, err_underflow all 0.
- cfg_start sampled high at edge N: busy and coord_valid are high after edge N, first coordinate (x0, y0) with sof.
- Throughput is one coordinate per cycle while ready is high and credit is available.
- All outputs are registers or decode only registers. No combinational path runs from coord_ready to coord_valid.
- A retire at edge M frees a credit, and coord_valid can rise after edge M.
- frame_done pulses in the cycle after inflight reaches 0 in DRAIN. In continuous mode, the next sof is offered in the cycle after frame_done.
- Reset asserted mid-frame clears everything immediately; err_underflow clears only on reset.

## Structure
- vector_pkg holds the coordinate typedef (fp, COORD_W wide) and the scan_state_t enum {IDLE, RUN, DRAIN}.
- One sub-module, credit_counter, is natural: it is parametrised by MAX_INFLIGHT, takes inc/dec, and provides count, has_credit and underflow.
- The top-level module holds the FSM, col/row counters and coordinate accumulators.

## Test plan
- H_RES=4, V_RES=2, x0=y0=0, step=0x00200000, ready held high:
  - Coordinates x = 0, 0x00200000, 0x00400000, 0x00600000 (eol) at y = 0, then the same at y = 0x00200000.
  - sof on beat 0 only; frame_done once; busy then falls.
- Same config, coord_ready toggled pseudo-randomly: same 8 beats in order, outputs stable during every stall, no beat dropped or duplicated.
- MAX_INFLIGHT=2, no retire: exactly 2 accepts, then coord_valid = 0. One retire pulse allows exactly one more accept.
- cfg_continuous=1, x0 changed to 0x01000000 mid-frame: the current frame is unaffected; the next frame starts at 0x01000000 with sof the cycle after frame_done.
- Reset asserted on beat 5:
  - All outputs return to reset values.
  - After release with cfg_continuous = 0 and no new cfg_start, coord_valid stays 0.
  - With cfg_continuous = 1, the frame restarts at (x0, y0) with sof after release.
- retire pulsed with inflight = 0: err_underflow sets and stays set, and inflight stays 0. Accept and retire in the same cycle leave inflight unchanged.
